// File: rtl/pipe_credit_fifo.sv
// Credit-issuing receive FIFO behind a stall-free fixed-latency pipeline.
// Optional PIPE_CREDIT_FIFO_CHECK_EN adds a sticky overflow flag and simulation checks.
module pipe_credit_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_CREDIT_FIFO_CHECK_EN
  ,
  output logic             overflow
`endif
);

  // Handshake: a beat transfers on a rising edge only when valid and ready are
  // both high; valid never depends on ready, and data is held while valid & !ready.
  // in_valid has no ready: every in_valid beat is pushed (credits prevent overflow).

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    occ;
  logic             issue_fire;
  logic             pop;
  logic             full;
  logic             push_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_ONE;
  endfunction

  assign issue_ready = rst_n & (cnt < FULL_CNT);
  assign out_valid   = (occ != '0);
  assign full        = (occ == FULL_CNT);
  assign issue_fire  = issue_valid & issue_ready;
  assign pop         = out_valid & out_ready;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign push_ok     = in_valid & (~full | pop);
  assign out_data    = mem[rd_ptr];

  // Credits cover beats in flight in the pipeline plus beats stored here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (issue_fire && !pop) begin
      cnt <= cnt + CNT_ONE;
    end else if (pop && !issue_fire && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (push_ok && !pop) begin
      occ <= occ + CNT_ONE;
    end else if (pop && !push_ok) begin
      occ <= occ - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)     rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Storage is deliberately left unreset; out_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= in_data;
  end

`ifdef PIPE_CREDIT_FIFO_CHECK_EN
  logic push_drop;
  logic credit_underflow;

  assign push_drop        = in_valid & full & ~pop;
  assign credit_underflow = pop & (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_drop || credit_underflow) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!push_drop) else $error("pipe_credit_fifo: push dropped while full");
      assert (!credit_underflow) else $error("pipe_credit_fifo: pop with no credit outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_pipe_credit_fifo.sv
// Bench for pipe_credit_fifo: a 2-stage valid-only pipeline (+1 per stage) feeds the
// FIFO; a queue/count model of credits and FIFO contents checks every cycle.
module tb_pipe_credit_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic [WIDTH-1:0] issue_data = '0;
  logic             issue_ready;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_CREDIT_FIFO_CHECK_EN
  logic             overflow;
`endif

  logic             force_v = 1'b0;
  logic [WIDTH-1:0] force_d = '0;
  logic             p1_v, p2_v;
  logic [WIDTH-1:0] p1_d, p2_d;

  int               n_cmp = 0;
  int               n_bad = 0;
  int               m_cnt = 0;
  int               m_occ = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  pipe_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data)
`ifdef PIPE_CREDIT_FIFO_CHECK_EN
    ,
    .overflow    (overflow)
`endif
  );

  // clock / reset-able environment pipeline
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1_d <= '0; p2_d <= '0;
    end else begin
      p1_v <= issue_valid & issue_ready;
      p1_d <= issue_data + 32'd1;
      p2_v <= p1_v;
      p2_d <= p1_d + 32'd1;
    end
  end

  assign in_valid = p2_v | force_v;
  assign in_data  = force_v ? force_d : p2_d;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle: called at a negedge, checks outputs against the model, advances it.
  task automatic drive_cycle(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    logic e_ready, e_valid, fire, pop, push;
    issue_valid = iv;
    issue_data  = id;
    out_ready   = ordy;
    #1;
    e_ready = (m_cnt < DEPTH);
    e_valid = (m_occ != 0);
    n_cmp++;
    if (issue_ready !== e_ready) begin
      n_bad++;
      $display("FAIL issue_ready: got %b want %b (credits %0d)", issue_ready, e_ready, m_cnt);
    end
    n_cmp++;
    if (out_valid !== e_valid) begin
      n_bad++;
      $display("FAIL out_valid: got %b want %b (occupancy %0d)", out_valid, e_valid, m_occ);
    end
    if (e_valid && exp_q.size() > 0) begin
      n_cmp++;
      if (out_data !== exp_q[0]) begin
        n_bad++;
        $display("FAIL out_data: got %h want %h", out_data, exp_q[0]);
      end
    end
    if (prev_stall) begin
      n_cmp++;
      if (out_data !== prev_data) begin
        n_bad++;
        $display("FAIL stall_hold: got %h want %h", out_data, prev_data);
      end
    end
    fire = iv && e_ready;
    pop  = e_valid && ordy;
    push = in_valid && ((m_occ < DEPTH) || pop);
    prev_stall = e_valid && !ordy;
    prev_data  = (exp_q.size() > 0) ? exp_q[0] : '0;
    @(posedge clk);
    m_cnt = m_cnt + (fire ? 1 : 0) - (pop ? 1 : 0);
    m_occ = m_occ + (push ? 1 : 0) - (pop ? 1 : 0);
    if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
    if (fire) exp_q.push_back(id + 32'd2);
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_occ = 0;
    exp_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic check_in_reset(input string tag);
    n_cmp++;
    if (issue_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s issue_ready: got %b want 0", tag, issue_ready);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s out_valid: got %b want 0", tag, out_valid);
    end
`ifdef PIPE_CREDIT_FIFO_CHECK_EN
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL %s overflow: got %b want 0", tag, overflow);
    end
`endif
  endtask

  task automatic test_reset();
    issue_valid = 1'b1;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_in_reset("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    drive_cycle(1'b0, '0, 1'b0);
  endtask

  task automatic test_single_beat();
    int calls, lat;
    logic seen;
    logic [WIDTH-1:0] got;
    seen = 1'b0; lat = 0; got = '0;
    drive_cycle(1'b1, 32'h10, 1'b1);
    calls = 1;
    for (int k = 0; k < 10 && !seen; k++) begin
      if (out_valid) begin
        seen = 1'b1; lat = calls; got = out_data;
      end
      drive_cycle(1'b0, '0, 1'b1);
      calls++;
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL single_timeout: out_valid never rose within 10 cycles");
    end else begin
      n_cmp++;
      if (lat != 3) begin
        n_bad++;
        $display("FAIL single_latency: got %0d want 3", lat);
      end
      n_cmp++;
      if (got !== 32'h12) begin
        n_bad++;
        $display("FAIL single_data: got %h want 00000012", got);
      end
    end
    drive_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_credit_limit();
    int acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (issue_ready) acc++;
      drive_cycle(1'b1, $urandom(), 1'b0);
    end
    repeat (4) drive_cycle(1'b0, '0, 1'b0);
    n_cmp++;
    if (acc != DEPTH) begin
      n_bad++;
      $display("FAIL credit_accepted: got %0d want %0d", acc, DEPTH);
    end
`ifdef PIPE_CREDIT_FIFO_CHECK_EN
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL credit_overflow: got %b want 0", overflow);
    end
`endif
  endtask

  task automatic test_full_simultaneous();
    int pops = 0, fires = 0;
    for (int i = 0; i < 16; i++) begin
      if (i >= 6) begin
        if (out_valid) pops++;
        if (issue_ready) fires++;
      end
      drive_cycle(1'b1, $urandom(), 1'b1);
    end
    n_cmp++;
    if (pops != 10) begin
      n_bad++;
      $display("FAIL steady_pops: got %0d want 10", pops);
    end
    n_cmp++;
    if (fires != 10) begin
      n_bad++;
      $display("FAIL steady_issues: got %0d want 10", fires);
    end
    repeat (6) drive_cycle(1'b0, '0, 1'b1);
  endtask

  task automatic test_backpressure();
    int issued = 0, popped = 0;
    logic iv, ordy;
    for (int i = 0; i < 212; i++) begin
      iv   = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b0;
      ordy = (i < 200) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (iv && issue_ready) issued++;
      if (out_valid && ordy) popped++;
      drive_cycle(iv, $urandom(), ordy);
    end
    n_cmp++;
    if (popped != issued) begin
      n_bad++;
      $display("FAIL bp_count: popped %0d want %0d", popped, issued);
    end
    n_cmp++;
    if (issue_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_drained: issue_ready %b out_valid %b want 1 0", issue_ready, out_valid);
    end
  endtask

  task automatic test_drop_on_full();
    for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, $urandom(), 1'b0);
    repeat (4) drive_cycle(1'b0, '0, 1'b0);
    force_v = 1'b1;
    force_d = 32'hDEAD_BEEF;
    drive_cycle(1'b0, '0, 1'b0);
    force_v = 1'b0;
    repeat (3) drive_cycle(1'b0, '0, 1'b0);
`ifdef PIPE_CREDIT_FIFO_CHECK_EN
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_set: got %b want 1", overflow);
    end
`endif
    repeat (DEPTH + 2) drive_cycle(1'b0, '0, 1'b1);
`ifdef PIPE_CREDIT_FIFO_CHECK_EN
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_sticky: got %b want 1", overflow);
    end
`endif
  endtask

  task automatic test_reset_mid_traffic();
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, $urandom(), 1'($urandom_range(0, 1)));
    issue_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_in_reset("reset_async");
    repeat (2) @(posedge clk);
    #1;
    check_in_reset("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) drive_cycle(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
    repeat (10) drive_cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_credit_limit();
    test_full_simultaneous();
    test_backpressure();
    test_drop_on_full();
    test_reset_mid_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
